// File: rtl/stage_modulator_multi.sv
`default_nettype none
// ============================================================================
// Module      : stage_modulator_multi
// Description : Multi-operator phase modulation stage. Each clock it takes
//               the raw unsigned phase of one voice/operator slot. It then
//               adds the latest stored outputs of the modulating operators of
//               the same voice, as selected by that slot's algorithm word.
//               Each operator has its own pipeline stage. The slot's own
//               operator is added as scaled self-feedback. The final phase is
//               either wrapped or saturated to a signed PHASE_WIDTH+1 value.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_Clock / i_Reset           clock, asynchronous active-high reset
//   i_Valid, i_Phase, i_NoteOn  slot input (valid, raw phase, note gate)
//   i_VoiceOperator             slot ID {voice, op}
//   o_Valid, o_Phase, o_NoteOn  slot output, NUM_OPERATORS+2 cycles later
//   o_VoiceOperator             delayed slot ID
//   o_AlgorithmWord             algorithm word used for this slot
//   i_OperatorWriteback*        operator output writeback (strobe, ID, value)
//   i_AlgorithmWriteEnable,
//   i_ConfigWriteAddr/Data      algorithm word configuration write
// ----------------------------------------------------------------------------
// Algorithm word: [NUM_OPERATORS+2:NUM_OPERATORS] FeedbackLevel,
//                 [NUM_OPERATORS-1:0]             ModulateWithOP mask
// ============================================================================
module stage_modulator_multi #(
    parameter int NUM_OPERATORS = 8,
    parameter int NUM_VOICES    = 32,
    parameter int PHASE_WIDTH   = 16,
    parameter int OUT_WIDTH     = 16,
    parameter int SATURATE      = 0
) (
    input  logic                                                  i_Clock,
    input  logic                                                  i_Reset,
    input  logic                                                  i_Valid,
    input  logic [PHASE_WIDTH-1:0]                                i_Phase,
    input  logic                                                  i_NoteOn,
    input  logic [$clog2(NUM_VOICES)+$clog2(NUM_OPERATORS)-1:0]   i_VoiceOperator,
    output logic                                                  o_Valid,
    output logic [PHASE_WIDTH:0]                                  o_Phase,
    output logic                                                  o_NoteOn,
    output logic [$clog2(NUM_VOICES)+$clog2(NUM_OPERATORS)-1:0]   o_VoiceOperator,
    output logic [NUM_OPERATORS+2:0]                              o_AlgorithmWord,
    input  logic                                                  i_OperatorWritebackValid,
    input  logic [$clog2(NUM_VOICES)+$clog2(NUM_OPERATORS)-1:0]   i_OperatorWritebackID,
    input  logic [OUT_WIDTH-1:0]                                  i_OperatorWritebackValue,
    input  logic                                                  i_AlgorithmWriteEnable,
    input  logic [$clog2(NUM_VOICES)+$clog2(NUM_OPERATORS)-1:0]   i_ConfigWriteAddr,
    input  logic [15:0]                                           i_ConfigWriteData
);

    localparam int OPW   = $clog2(NUM_OPERATORS);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int IDW   = VW + OPW;
    localparam int SLOTS = 1 << IDW;
    localparam int AW    = NUM_OPERATORS + 3;
    // Guard bits: up to NUM_OPERATORS full-scale signed terms are added to an
    // unsigned phase, so the sum never overflows before the final stage.
    localparam int ACCW  = PHASE_WIDTH + 2 + OPW;
    localparam int NOPS  = NUM_OPERATORS;

    // ------------------------------------------------------------------------
    // Algorithm memory. It has a synchronous write and an asynchronous read.
    // A slot that enters in the same cycle as a write latches the old word.
    // ------------------------------------------------------------------------
    logic [SLOTS-1:0][AW-1:0] algo_mem_q;
    logic [AW-1:0]            cfg_word;

    if (AW < 16) begin : g_cfg_narrow
        wire unused_cfg_hi = ^i_ConfigWriteData[15:AW];
        assign cfg_word = i_ConfigWriteData[AW-1:0];
    end else begin : g_cfg_wide
        assign cfg_word = AW'(i_ConfigWriteData);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            algo_mem_q <= '0;
        end else if (i_AlgorithmWriteEnable) begin
            algo_mem_q[i_ConfigWriteAddr] <= cfg_word;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline registers. Index 0 is the input register. Index j (1..NOPS)
    // holds the slot after the contribution of op j-1 has been added.
    // ------------------------------------------------------------------------
    logic [NOPS:0]           valid_q, valid_d;
    logic [NOPS:0]           note_q,  note_d;
    logic [NOPS:0][IDW-1:0]  id_q,    id_d;
    logic [NOPS:0][AW-1:0]   word_q,  word_d;
    logic [NOPS:0][ACCW-1:0] acc_q,   acc_d;

    always_comb begin
        valid_d = {valid_q[NOPS-1:0], i_Valid};
        note_d  = {note_q[NOPS-1:0],  i_NoteOn};
        id_d    = {id_q[NOPS-1:0],    i_VoiceOperator};
        word_d  = {word_q[NOPS-1:0],  algo_mem_q[i_VoiceOperator]};
    end

    // Unsigned phase zero-extended into the signed accumulator
    assign acc_d[0] = {{(ACCW-PHASE_WIDTH){1'b0}}, i_Phase};

    // ------------------------------------------------------------------------
    // One accumulate stage per operator. Each stage has its own copy of the
    // operator-output memory, so every stage gets an independent read port.
    // Each read is asynchronous and happens before the write at the next
    // edge. A writeback in the read cycle therefore reaches only later slots.
    // ------------------------------------------------------------------------
    for (genvar j = 1; j <= NOPS; j++) begin : g_stage
        localparam logic [OPW-1:0] OP_IDX = OPW'(j - 1);

        logic [SLOTS-1:0][OUT_WIDTH-1:0] op_mem_q;
        logic [IDW-1:0]                  rd_addr;
        logic [OUT_WIDTH-1:0]            stored;
        logic signed [ACCW-1:0]          stored_ext;
        logic signed [ACCW-1:0]          fb_scaled;
        logic [2:0]                      fb_level;
        logic [3:0]                      fb_shift;
        logic                            is_self;
        logic                            use_op;
        logic [ACCW-1:0]                 contrib;

        always_ff @(posedge i_Clock or posedge i_Reset) begin
            if (i_Reset) begin
                op_mem_q <= '0;
            end else if (i_OperatorWritebackValid) begin
                op_mem_q[i_OperatorWritebackID] <= i_OperatorWritebackValue;
            end
        end

        assign rd_addr    = {id_q[j-1][IDW-1:OPW], OP_IDX};
        assign stored     = op_mem_q[rd_addr];
        assign stored_ext = {{(ACCW-OUT_WIDTH){stored[OUT_WIDTH-1]}}, stored};
        assign fb_level   = word_q[j-1][AW-1:NOPS];
        assign fb_shift   = 4'd8 - {1'b0, fb_level};
        // Kept in its own signed net so the shift stays arithmetic
        assign fb_scaled  = stored_ext >>> fb_shift;
        assign is_self    = (id_q[j-1][OPW-1:0] == OP_IDX);
        assign use_op     = word_q[j-1][j-1];

        always_comb begin
            contrib = '0;
            if (use_op) begin
                if (!is_self) begin
                    contrib = stored_ext;
                end else if (fb_level != 3'd0) begin
                    contrib = fb_scaled;
                end
            end
        end

        assign acc_d[j] = acc_q[j-1] + contrib;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            valid_q <= '0;
            note_q  <= '0;
            id_q    <= '0;
            word_q  <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            note_q  <= note_d;
            id_q    <= id_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Final stage: reduce the accumulator to signed PHASE_WIDTH+1
    // ------------------------------------------------------------------------
    logic [PHASE_WIDTH:0] phase_d;

    if (SATURATE != 0) begin : g_sat
        localparam logic signed [ACCW-1:0] SAT_MAX =
            {{(ACCW-PHASE_WIDTH){1'b0}}, {PHASE_WIDTH{1'b1}}};
        localparam logic signed [ACCW-1:0] SAT_MIN =
            {{(ACCW-PHASE_WIDTH){1'b1}}, {PHASE_WIDTH{1'b0}}};

        always_comb begin
            phase_d = acc_q[NOPS][PHASE_WIDTH:0];
            if ($signed(acc_q[NOPS]) > SAT_MAX) begin
                phase_d = {1'b0, {PHASE_WIDTH{1'b1}}};
            end else if ($signed(acc_q[NOPS]) < SAT_MIN) begin
                phase_d = {1'b1, {PHASE_WIDTH{1'b0}}};
            end
        end
    end else begin : g_wrap
        wire unused_acc_hi = ^acc_q[NOPS][ACCW-1:PHASE_WIDTH+1];
        assign phase_d = acc_q[NOPS][PHASE_WIDTH:0];
    end

    logic                 out_valid_q;
    logic [PHASE_WIDTH:0] out_phase_q;
    logic                 out_note_q;
    logic [IDW-1:0]       out_id_q;
    logic [AW-1:0]        out_word_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            out_valid_q <= 1'b0;
            out_phase_q <= '0;
            out_note_q  <= 1'b0;
            out_id_q    <= '0;
            out_word_q  <= '0;
        end else begin
            out_valid_q <= valid_q[NOPS];
            out_phase_q <= phase_d;
            out_note_q  <= note_q[NOPS];
            out_id_q    <= id_q[NOPS];
            out_word_q  <= word_q[NOPS];
        end
    end

    assign o_Valid         = out_valid_q;
    assign o_Phase         = out_phase_q;
    assign o_NoteOn        = out_note_q;
    assign o_VoiceOperator = out_id_q;
    assign o_AlgorithmWord = out_word_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_modulator_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_modulator_multi
// Description : Directed self-checking bench for stage_modulator_multi. It
//               runs a wrapping instance and a saturating instance side by
//               side on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_modulator_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_note, wb_valid, cfg_we;
    logic [15:0] in_phase, wb_value, cfg_data;
    logic [7:0]  in_id, wb_id, cfg_addr;

    logic        out_valid, out_note, sat_valid, sat_note;
    logic [16:0] out_phase, sat_phase;
    logic [7:0]  out_id, sat_id;
    logic [10:0] out_word, sat_word;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage_modulator_multi dut (
        .i_Clock(clk), .i_Reset(rst), .i_Valid(in_valid), .i_Phase(in_phase),
        .i_NoteOn(in_note), .i_VoiceOperator(in_id),
        .o_Valid(out_valid), .o_Phase(out_phase), .o_NoteOn(out_note),
        .o_VoiceOperator(out_id), .o_AlgorithmWord(out_word),
        .i_OperatorWritebackValid(wb_valid), .i_OperatorWritebackID(wb_id),
        .i_OperatorWritebackValue(wb_value), .i_AlgorithmWriteEnable(cfg_we),
        .i_ConfigWriteAddr(cfg_addr), .i_ConfigWriteData(cfg_data)
    );

    stage_modulator_multi #(.SATURATE(1)) dut_sat (
        .i_Clock(clk), .i_Reset(rst), .i_Valid(in_valid), .i_Phase(in_phase),
        .i_NoteOn(in_note), .i_VoiceOperator(in_id),
        .o_Valid(sat_valid), .o_Phase(sat_phase), .o_NoteOn(sat_note),
        .o_VoiceOperator(sat_id), .o_AlgorithmWord(sat_word),
        .i_OperatorWritebackValid(wb_valid), .i_OperatorWritebackID(wb_id),
        .i_OperatorWritebackValue(wb_value), .i_AlgorithmWriteEnable(cfg_we),
        .i_ConfigWriteAddr(cfg_addr), .i_ConfigWriteData(cfg_data)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slot();
        in_valid = 1'b0; in_phase = '0; in_note = 1'b0; in_id = '0;
    endtask

    task automatic wr_algo(input logic [7:0] addr, input logic [15:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        tick();
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic wr_op(input logic [7:0] id, input logic [15:0] val);
        wb_valid = 1'b1; wb_id = id; wb_value = val;
        tick();
        wb_valid = 1'b0; wb_id = '0; wb_value = '0;
    endtask

    // Sends one isolated slot and checks it 10 cycles later
    task automatic run_slot(input string tag, input logic [15:0] phase, input logic [7:0] id,
                            input logic note, input logic [16:0] exp_phase,
                            input logic [16:0] exp_sat, input logic [10:0] exp_word);
        in_valid = 1'b1; in_phase = phase; in_id = id; in_note = note;
        tick();
        clear_slot();
        repeat (8) tick();
        check_value({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        tick();
        check_value({tag, "_valid"},    32'(out_valid), 32'd1);
        check_value({tag, "_phase"},    32'(out_phase), 32'(exp_phase));
        check_value({tag, "_satphase"}, 32'(sat_phase), 32'(exp_sat));
        check_value({tag, "_id"},       32'(out_id),    32'(id));
        check_value({tag, "_note"},     32'(out_note),  32'(note));
        check_value({tag, "_word"},     32'(out_word),  32'(exp_word));
    endtask

    logic [11:0] pat;

    initial begin
        rst = 1'b1;
        clear_slot();
        wb_valid = 1'b0; wb_id = '0; wb_value = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        tick();
        tick();
        check_value("reset_valid", 32'(out_valid), 32'd0);
        check_value("reset_phase", 32'(out_phase), 32'd0);
        check_value("reset_word",  32'(out_word),  32'd0);
        rst = 1'b0;
        tick();

        // 1: all-zero algorithm passes the phase through
        run_slot("t1", 16'h1234, 8'h00, 1'b1, 17'h01234, 17'h01234, 11'h000);

        // 2: voice 1 op 0 modulated by op 1 = -0x100
        wr_algo(8'h08, 16'h0002);
        wr_op(8'h09, 16'hFF00);
        run_slot("t2", 16'h0050, 8'h08, 1'b0, 17'h1FF50, 17'h1FF50, 11'h002);

        // 3: self-feedback on voice 2 op 3
        wr_algo(8'h13, 16'h0108);
        wr_op(8'h13, 16'h4000);
        run_slot("t3_fb1", 16'h0000, 8'h13, 1'b1, 17'h00080, 17'h00080, 11'h108);
        wr_algo(8'h13, 16'h0008);
        run_slot("t3_fb0", 16'h0000, 8'h13, 1'b1, 17'h00000, 17'h00000, 11'h008);
        wr_algo(8'h13, 16'h0700);
        run_slot("t3_nomask", 16'h0000, 8'h13, 1'b0, 17'h00000, 17'h00000, 11'h700);
        wr_algo(8'h13, 16'h0708);
        run_slot("t3_fb7", 16'h0000, 8'h13, 1'b0, 17'h02000, 17'h02000, 11'h708);
        wr_op(8'h13, 16'hC000);
        run_slot("t3_fb7neg", 16'h0000, 8'h13, 1'b0, 17'h1E000, 17'h1E000, 11'h708);

        // 4: overflow in both directions
        wr_algo(8'h1A, 16'h0003);
        wr_op(8'h18, 16'h7FFF);
        wr_op(8'h19, 16'h7FFF);
        run_slot("t4_pos", 16'hFFFF, 8'h1A, 1'b1, 17'h1FFFD, 17'h0FFFF, 11'h003);
        wr_algo(8'h1B, 16'h0007);
        wr_op(8'h18, 16'h8000);
        wr_op(8'h19, 16'h8000);
        wr_op(8'h1A, 16'h8000);
        run_slot("t4_neg", 16'h0000, 8'h1B, 1'b1, 17'h08000, 17'h10000, 11'h007);

        // 5a: writeback in the read cycle of slot A reaches only slot B
        wr_algo(8'h21, 16'h0001);
        wr_op(8'h20, 16'h0100);
        in_valid = 1'b1; in_phase = '0; in_id = 8'h21;
        tick();
        wb_valid = 1'b1; wb_id = 8'h20; wb_value = 16'h0200;
        tick();
        clear_slot();
        wb_valid = 1'b0; wb_id = '0; wb_value = '0;
        repeat (8) tick();
        check_value("t5_wb_old", 32'(out_phase), 32'h00100);
        tick();
        check_value("t5_wb_new", 32'(out_phase), 32'h00200);

        // 5b: config write in the entry cycle of slot C reaches only slot D
        wr_algo(8'h29, 16'h0001);
        wr_op(8'h28, 16'h0010);
        in_valid = 1'b1; in_phase = 16'h0005; in_id = 8'h29;
        cfg_we = 1'b1; cfg_addr = 8'h29; cfg_data = 16'h0000;
        tick();
        cfg_we = 1'b0; cfg_addr = '0;
        tick();
        clear_slot();
        repeat (8) tick();
        check_value("t5_cfg_old_phase", 32'(out_phase), 32'h00015);
        check_value("t5_cfg_old_word",  32'(out_word),  32'h001);
        tick();
        check_value("t5_cfg_new_phase", 32'(out_phase), 32'h00005);
        check_value("t5_cfg_new_word",  32'(out_word),  32'h000);

        // 6a: back-to-back slots with toggling valid
        pat = 12'b0111_0010_1101;
        for (int t = 0; t < 21; t++) begin
            if (t < 12) begin
                in_valid = pat[t]; in_phase = 16'h0100 + 16'(t); in_id = 8'h00;
            end else begin
                clear_slot();
            end
            tick();
            if (t >= 9) begin
                check_value($sformatf("t6_valid_%0d", t - 9), 32'(out_valid), 32'(pat[t-9]));
                if (pat[t-9])
                    check_value($sformatf("t6_phase_%0d", t - 9), 32'(out_phase),
                                32'h100 + 32'(t - 9));
            end
        end

        // 6b: reset mid-stream
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; in_phase = 16'h0200 + 16'(k); in_id = 8'h00;
            tick();
        end
        check_value("t6_pre_reset_valid", 32'(out_valid), 32'd1);
        check_value("t6_pre_reset_phase", 32'(out_phase), 32'h00202);
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_async_valid",     32'(out_valid), 32'd0);
        check_value("t6_async_phase",     32'(out_phase), 32'd0);
        check_value("t6_async_sat_valid", 32'(sat_valid), 32'd0);
        check_value("t6_async_id",        32'(out_id),    32'd0);
        clear_slot();
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_value($sformatf("t6_no_stale_%0d", k), 32'(out_valid), 32'd0);
        end
        // Memories were cleared: voice 1 op 0 no longer sees op 1
        run_slot("t6_post", 16'h0050, 8'h08, 1'b0, 17'h00050, 17'h00050, 11'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
